stage_writeback: RTL and testbench

- Final CPU pipeline stage. Sits directly downstream of the memory access stage and consumes its registered outputs plus the synchronous data-memory read word.
- Extracts, aligns and sign/zero-extends load data, then drives the register-file write port and the async forwarding signals.
- Retires instructions and maintains the 64-bit cycle and instret counters, including a CSR write port to those counters.

---
 rtl/cpu_common.sv | 34 +++
 rtl/stage_writeback_load_extract.sv | 31 +++
 rtl/stage_writeback.sv | 117 +++++++++++
 tb/tb_stage_writeback.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_common.sv
// Shared CPU definitions: memory-access sizes, the NOP program counter and
// counter-CSR select encodings used across the pipeline stages.
package cpu_common;

   typedef enum logic [2:0] {
      MA_SIZE_B  = 3'b000,
      MA_SIZE_H  = 3'b001,
      MA_SIZE_W  = 3'b010,
      MA_SIZE_BU = 3'b100,
      MA_SIZE_HU = 3'b101
   } ma_size_t;

   // PC value the upstream stage presents when it holds a bubble.
   localparam logic [31:0] NOP_PC = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      CNT_CYCLE_LO   = 2'b00,
      CNT_CYCLE_HI   = 2'b01,
      CNT_INSTRET_LO = 2'b10,
      CNT_INSTRET_HI = 2'b11
   } cnt_sel_t;

   function automatic logic ma_misaligned(input ma_size_t size, input logic [1:0] align);
      logic r_mis;
      r_mis = 1'b0;
      case (size)
         MA_SIZE_H, MA_SIZE_HU: r_mis = align[0];
         MA_SIZE_W:             r_mis = (align != 2'b00);
         default:               r_mis = 1'b0;
      endcase
      return r_mis;
   endfunction

endpackage

// File: rtl/stage_writeback_load_extract.sv
// Combinational load-data aligner/extender with misaligned-access detection.
module load_extract
   import cpu_common::*;
(
   input  logic [31:0] i_word,
   input  ma_size_t    i_size,
   input  logic [1:0]  i_align,
   input  logic        i_load,
   output logic [31:0] o_data,
   output logic        o_misaligned
);

   logic [31:0] w_shifted;

   assign w_shifted = i_word >> {i_align, 3'b000};

   always_comb begin
      o_data = w_shifted;
      case (i_size)
         MA_SIZE_B:  o_data = {{24{w_shifted[7]}},  w_shifted[7:0]};
         MA_SIZE_BU: o_data = {24'h00_0000,         w_shifted[7:0]};
         MA_SIZE_H:  o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
         MA_SIZE_HU: o_data = {16'h0000,            w_shifted[15:0]};
         MA_SIZE_W:  o_data = w_shifted;
         default:    o_data = w_shifted;
      endcase
   end

   assign o_misaligned = i_load & ma_misaligned(i_size, i_align);

endmodule

// File: rtl/stage_writeback.sv
// Write-back stage: load extraction, regfile write/forwarding, retirement and
// the 64-bit cycle/instret counters with their CSR write port.
module stage_writeback
   import cpu_common::*;
#(
   parameter logic [63:0] CYCLE_RESET   = 64'd0,
   parameter logic [63:0] INSTRET_RESET = 64'd0
)(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [31:0] dmem_read_data_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] ir_i,
   input  logic        load_i,
   input  ma_size_t    ma_size_i,
   input  logic [1:0]  ma_alignment_i,
   input  logic [31:0] wb_data_i,
   input  logic        wb_valid_i,
   input  logic        cnt_write_i,
   input  logic [1:0]  cnt_sel_i,
   input  logic [31:0] cnt_wdata_i,
   input  logic [1:0]  cnt_inhibit_i,
   output logic [4:0]  wb_addr_async_o,
   output logic [31:0] wb_data_async_o,
   output logic        wb_valid_async_o,
   output logic        empty_async_o,
   output logic [4:0]  wb_addr_o,
   output logic [31:0] wb_data_o,
   output logic        wb_valid_o,
   output logic        retired_o,
   output logic        misaligned_o,
   output logic [63:0] cycle_o,
   output logic [63:0] instret_o
);

   logic [31:0] w_ld_data;
   logic        w_misaligned;
   logic        w_empty;
   logic [4:0]  w_rd;
   logic        w_retire;
   cnt_sel_t    w_sel;
   logic [63:0] w_cycle_next;
   logic [63:0] w_instret_next;
   logic        w_unused_ir;

   logic [4:0]  r_wb_addr;
   logic [31:0] r_wb_data;
   logic        r_wb_valid;
   logic        r_retired;
   logic        r_misaligned;
   logic [63:0] r_cycle;
   logic [63:0] r_instret;

   load_extract u_load_extract (
      .i_word       (dmem_read_data_i),
      .i_size       (ma_size_i),
      .i_align      (ma_alignment_i),
      .i_load       (load_i),
      .o_data       (w_ld_data),
      .o_misaligned (w_misaligned)
   );

   assign w_rd        = ir_i[11:7];
   assign w_unused_ir = ^{ir_i[31:12], ir_i[6:0]};
   assign w_empty     = (pc_i == NOP_PC);
   assign w_retire    = ~w_empty & ~w_misaligned;
   assign w_sel       = cnt_sel_t'(cnt_sel_i);

   assign wb_addr_async_o  = w_rd;
   assign wb_data_async_o  = load_i ? w_ld_data : wb_data_i;
   assign wb_valid_async_o = wb_valid_i & (w_rd != 5'd0) & ~w_misaligned & ~w_empty;
   assign empty_async_o    = w_empty;

   // A CSR write to a half replaces that counter's increment for the cycle.
   always_comb begin
      w_cycle_next   = cnt_inhibit_i[0] ? r_cycle : r_cycle + 64'd1;
      w_instret_next = (w_retire && !cnt_inhibit_i[1]) ? r_instret + 64'd1 : r_instret;
      if (cnt_write_i) begin
         case (w_sel)
            CNT_CYCLE_LO:   w_cycle_next   = {r_cycle[63:32], cnt_wdata_i};
            CNT_CYCLE_HI:   w_cycle_next   = {cnt_wdata_i, r_cycle[31:0]};
            CNT_INSTRET_LO: w_instret_next = {r_instret[63:32], cnt_wdata_i};
            CNT_INSTRET_HI: w_instret_next = {cnt_wdata_i, r_instret[31:0]};
            default:        w_cycle_next   = r_cycle;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_wb_addr    <= '0;
         r_wb_data    <= '0;
         r_wb_valid   <= 1'b0;
         r_retired    <= 1'b0;
         r_misaligned <= 1'b0;
         r_cycle      <= CYCLE_RESET;
         r_instret    <= INSTRET_RESET;
      end else begin
         r_wb_addr    <= wb_addr_async_o;
         r_wb_data    <= wb_data_async_o;
         r_wb_valid   <= wb_valid_async_o;
         r_retired    <= w_retire;
         r_misaligned <= w_misaligned;
         r_cycle      <= w_cycle_next;
         r_instret    <= w_instret_next;
      end
   end

   assign wb_addr_o    = r_wb_addr;
   assign wb_data_o    = r_wb_data;
   assign wb_valid_o   = r_wb_valid;
   assign retired_o    = r_retired;
   assign misaligned_o = r_misaligned;
   assign cycle_o      = r_cycle;
   assign instret_o    = r_instret;

endmodule

// File: tb/tb_stage_writeback.sv
// Directed vector bench for stage_writeback: load extraction table plus
// counter wrap, CSR write priority, inhibit and mid-stream reset sequences.
module tb_stage_writeback;
   import cpu_common::*;

   localparam logic [63:0] CR = 64'h0000_0000_0000_0020;
   localparam logic [63:0] IR = 64'd100;

   logic        clk = 1'b0;
   logic        reset_i;
   logic [31:0] dmem_read_data_i, pc_i, ir_i, wb_data_i, cnt_wdata_i;
   logic        load_i, wb_valid_i, cnt_write_i;
   ma_size_t    ma_size_i;
   logic [1:0]  ma_alignment_i, cnt_sel_i, cnt_inhibit_i;
   logic [4:0]  wb_addr_async_o, wb_addr_o;
   logic [31:0] wb_data_async_o, wb_data_o;
   logic        wb_valid_async_o, empty_async_o, wb_valid_o, retired_o, misaligned_o;
   logic [63:0] cycle_o, instret_o;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [63:0] exp_cycle, exp_instret;
   logic [31:0] pc_ctr = 32'h0000_0100;

   stage_writeback #(.CYCLE_RESET(CR), .INSTRET_RESET(IR)) dut (
      .clk_i(clk), .reset_i(reset_i), .dmem_read_data_i(dmem_read_data_i),
      .pc_i(pc_i), .ir_i(ir_i), .load_i(load_i), .ma_size_i(ma_size_i),
      .ma_alignment_i(ma_alignment_i), .wb_data_i(wb_data_i), .wb_valid_i(wb_valid_i),
      .cnt_write_i(cnt_write_i), .cnt_sel_i(cnt_sel_i), .cnt_wdata_i(cnt_wdata_i),
      .cnt_inhibit_i(cnt_inhibit_i), .wb_addr_async_o(wb_addr_async_o),
      .wb_data_async_o(wb_data_async_o), .wb_valid_async_o(wb_valid_async_o),
      .empty_async_o(empty_async_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
      .wb_valid_o(wb_valid_o), .retired_o(retired_o), .misaligned_o(misaligned_o),
      .cycle_o(cycle_o), .instret_o(instret_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        ld;
      ma_size_t    sz;
      logic [1:0]  al;
      logic [31:0] dm;
      logic [31:0] wd;
      logic        wv;
      logic [4:0]  rd;
      logic        nop;
      logic [31:0] e_data;
      logic        e_valid;
      logic        e_mis;
      logic        e_ret;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ld, input ma_size_t sz, input logic [1:0] al,
                        input logic [31:0] dm, input logic [31:0] wd, input logic wv,
                        input logic [4:0] rd, input logic nop);
      load_i = ld; ma_size_i = sz; ma_alignment_i = al; dmem_read_data_i = dm;
      wb_data_i = wd; wb_valid_i = wv; ir_i = {20'h0, rd, ld ? 7'h03 : 7'h33};
      pc_ctr = pc_ctr + 32'd4;
      pc_i = nop ? NOP_PC : pc_ctr;
   endtask

   // Expected counter update from the bench's own view of the inputs, then one clock.
   task automatic tick(input logic ret);
      if (reset_i) begin
         exp_cycle = CR; exp_instret = IR;
      end else begin
         if (cnt_write_i && cnt_sel_i == 2'b00)      exp_cycle = {exp_cycle[63:32], cnt_wdata_i};
         else if (cnt_write_i && cnt_sel_i == 2'b01) exp_cycle = {cnt_wdata_i, exp_cycle[31:0]};
         else if (!cnt_inhibit_i[0])                 exp_cycle = exp_cycle + 64'd1;
         if (cnt_write_i && cnt_sel_i == 2'b10)      exp_instret = {exp_instret[63:32], cnt_wdata_i};
         else if (cnt_write_i && cnt_sel_i == 2'b11) exp_instret = {cnt_wdata_i, exp_instret[31:0]};
         else if (ret && !cnt_inhibit_i[1])          exp_instret = exp_instret + 64'd1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cnt(input string tag);
      chk({tag, " cycle"}, cycle_o, exp_cycle);
      chk({tag, " instret"}, instret_o, exp_instret);
   endtask

   initial begin
      vecs[0]  = '{1'b1, MA_SIZE_B,  2'd2, 32'h1280_FF34, 32'h0,         1'b1, 5'd3,  1'b0, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b1};
      vecs[1]  = '{1'b1, MA_SIZE_BU, 2'd2, 32'h1280_FF34, 32'h0,         1'b1, 5'd3,  1'b0, 32'h0000_0080, 1'b1, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, MA_SIZE_H,  2'd1, 32'h1280_FF34, 32'h0,         1'b1, 5'd5,  1'b0, 32'hFFFF_80FF, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, MA_SIZE_W,  2'd0, 32'hAAAA_AAAA, 32'h0000_1234, 1'b1, 5'd0,  1'b0, 32'h0000_1234, 1'b0, 1'b0, 1'b1};
      vecs[4]  = '{1'b1, MA_SIZE_H,  2'd2, 32'h8001_0000, 32'h0,         1'b1, 5'd7,  1'b0, 32'hFFFF_8001, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, MA_SIZE_HU, 2'd0, 32'h1234_F00D, 32'h0,         1'b1, 5'd8,  1'b0, 32'h0000_F00D, 1'b1, 1'b0, 1'b1};
      vecs[6]  = '{1'b1, MA_SIZE_W,  2'd0, 32'hDEAD_BEEF, 32'h0,         1'b1, 5'd31, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, MA_SIZE_W,  2'd2, 32'hDEAD_BEEF, 32'h0,         1'b1, 5'd2,  1'b0, 32'h0000_DEAD, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, MA_SIZE_B,  2'd3, 32'h7F00_0000, 32'h0,         1'b1, 5'd10, 1'b0, 32'h0000_007F, 1'b1, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, MA_SIZE_W,  2'd0, 32'h0,         32'h5555_0000, 1'b1, 5'd4,  1'b1, 32'h5555_0000, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b0, MA_SIZE_W,  2'd0, 32'h0,         32'hCAFE_F00D, 1'b1, 5'd9,  1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{1'b0, MA_SIZE_W,  2'd0, 32'h0,         32'h0000_0042, 1'b0, 5'd9,  1'b0, 32'h0000_0042, 1'b0, 1'b0, 1'b1};
      vecs[12] = '{1'b1, MA_SIZE_HU, 2'd3, 32'h1234_5678, 32'h0,         1'b1, 5'd11, 1'b0, 32'h0000_0012, 1'b0, 1'b1, 1'b0};
      vecs[13] = '{1'b1, MA_SIZE_BU, 2'd1, 32'h0000_AB00, 32'h0,         1'b1, 5'd12, 1'b0, 32'h0000_00AB, 1'b1, 1'b0, 1'b1};

      reset_i = 1'b1; cnt_write_i = 1'b0; cnt_sel_i = 2'b00; cnt_wdata_i = '0; cnt_inhibit_i = 2'b00;
      exp_cycle = '0; exp_instret = '0;
      drive(1'b0, MA_SIZE_W, 2'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1);
      tick(1'b0);
      tick(1'b0);
      chk("reset cycle", cycle_o, CR);
      chk("reset instret", instret_o, IR);
      chk("reset wb_valid_o", {63'd0, wb_valid_o}, 64'd0);
      chk("reset retired_o", {63'd0, retired_o}, 64'd0);
      chk("reset nop empty", {63'd0, empty_async_o}, 64'd1);

      reset_i = 1'b0;
      tick(1'b0);
      chk("first count cycle", cycle_o, CR + 64'd1);
      chk("nop no retire instret", instret_o, IR);

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].ld, vecs[i].sz, vecs[i].al, vecs[i].dm, vecs[i].wd, vecs[i].wv, vecs[i].rd, vecs[i].nop);
         #1;
         chk($sformatf("v%0d data_async", i), {32'd0, wb_data_async_o}, {32'd0, vecs[i].e_data});
         chk($sformatf("v%0d valid_async", i), {63'd0, wb_valid_async_o}, {63'd0, vecs[i].e_valid});
         chk($sformatf("v%0d addr_async", i), {59'd0, wb_addr_async_o}, {59'd0, vecs[i].rd});
         chk($sformatf("v%0d empty_async", i), {63'd0, empty_async_o}, {63'd0, vecs[i].nop});
         tick(vecs[i].e_ret);
         chk($sformatf("v%0d wb_addr_o", i), {59'd0, wb_addr_o}, {59'd0, vecs[i].rd});
         chk($sformatf("v%0d wb_data_o", i), {32'd0, wb_data_o}, {32'd0, vecs[i].e_data});
         chk($sformatf("v%0d wb_valid_o", i), {63'd0, wb_valid_o}, {63'd0, vecs[i].e_valid});
         chk($sformatf("v%0d retired_o", i), {63'd0, retired_o}, {63'd0, vecs[i].e_ret});
         chk($sformatf("v%0d misaligned_o", i), {63'd0, misaligned_o}, {63'd0, vecs[i].e_mis});
         chk_cnt($sformatf("v%0d", i));
      end

      // instret carry across the 32-bit boundary
      drive(1'b0, MA_SIZE_W, 2'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1);
      cnt_write_i = 1'b1; cnt_sel_i = 2'b10; cnt_wdata_i = 32'hFFFF_FFFF;
      tick(1'b0);
      cnt_sel_i = 2'b11; cnt_wdata_i = 32'h0;
      tick(1'b0);
      cnt_write_i = 1'b0;
      chk("instret preset", instret_o, 64'h0000_0000_FFFF_FFFF);
      drive(1'b0, MA_SIZE_W, 2'd0, 32'h0, 32'h1, 1'b1, 5'd1, 1'b0);
      tick(1'b1);
      chk("instret carry", instret_o, 64'h0000_0001_0000_0000);

      // cycle all-ones wraps to zero
      drive(1'b0, MA_SIZE_W, 2'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1);
      cnt_write_i = 1'b1; cnt_sel_i = 2'b00; cnt_wdata_i = 32'hFFFF_FFFF;
      tick(1'b0);
      cnt_sel_i = 2'b01;
      tick(1'b0);
      chk("cycle preset ones", cycle_o, 64'hFFFF_FFFF_FFFF_FFFF);
      cnt_write_i = 1'b0;
      tick(1'b0);
      chk("cycle wrap", cycle_o, 64'h0);

      // write beats increment, other half kept
      cnt_write_i = 1'b1; cnt_sel_i = 2'b01; cnt_wdata_i = 32'h5;
      tick(1'b0);
      chk("cycle hi write", cycle_o, 64'h0000_0005_0000_0000);
      cnt_sel_i = 2'b00; cnt_wdata_i = 32'h10;
      tick(1'b0);
      chk("cycle lo write", cycle_o, 64'h0000_0005_0000_0010);
      cnt_write_i = 1'b0;
      tick(1'b0);
      chk("cycle after write", cycle_o, 64'h0000_0005_0000_0011);

      drive(1'b0, MA_SIZE_W, 2'd0, 32'h0, 32'h2, 1'b1, 5'd1, 1'b0);
      cnt_write_i = 1'b1; cnt_sel_i = 2'b10; cnt_wdata_i = 32'h77;
      tick(1'b1);
      cnt_write_i = 1'b0;
      chk("instret write beats retire", instret_o, 64'h0000_0001_0000_0077);

      cnt_inhibit_i = 2'b11;
      tick(1'b1);
      chk("inhibit cycle", cycle_o, 64'h0000_0005_0000_0012);
      chk("inhibit instret", instret_o, 64'h0000_0001_0000_0077);
      chk_cnt("inhibit");
      cnt_inhibit_i = 2'b00;

      // reset with a load in flight
      drive(1'b1, MA_SIZE_W, 2'd0, 32'h1357_9BDF, 32'h0, 1'b1, 5'd6, 1'b0);
      reset_i = 1'b1;
      tick(1'b0);
      chk("midreset wb_addr_o", {59'd0, wb_addr_o}, 64'd0);
      chk("midreset wb_data_o", {32'd0, wb_data_o}, 64'd0);
      chk("midreset wb_valid_o", {63'd0, wb_valid_o}, 64'd0);
      chk("midreset retired_o", {63'd0, retired_o}, 64'd0);
      chk("midreset misaligned_o", {63'd0, misaligned_o}, 64'd0);
      chk("midreset cycle", cycle_o, CR);
      chk("midreset instret", instret_o, IR);
      chk("midreset async data", {32'd0, wb_data_async_o}, 64'h1357_9BDF);
      drive(1'b0, MA_SIZE_W, 2'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1);
      reset_i = 1'b0;
      tick(1'b0);
      drive(1'b0, MA_SIZE_W, 2'd0, 32'h0, 32'h9, 1'b1, 5'd1, 1'b0);
      tick(1'b1);
      chk("post reset retire", instret_o, IR + 64'd1);
      chk("post reset cycle", cycle_o, CR + 64'd2);
      chk("post reset retired_o", {63'd0, retired_o}, 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
